// File: rtl/idma_desc64_mc_pkg.sv
// Shared definitions for the multi-channel desc64 APB register front end:
// register map, bit positions, access FSM encoding and default APB structs.
package idma_desc64_mc_pkg;

    localparam int unsigned ChanStride = 32'h10;

    // Word offsets within a channel window (paddr[3:2])
    localparam logic [1:0] RegCtrl   = 2'd0;
    localparam logic [1:0] RegStatus = 2'd1;
    localparam logic [1:0] RegDescLo = 2'd2;
    localparam logic [1:0] RegDescHi = 2'd3;

    localparam int unsigned CtrlEnBit      = 0;
    localparam int unsigned CtrlFlushBit   = 1;
    localparam int unsigned StatusFullBit  = 8;
    localparam int unsigned StatusEmptyBit = 9;

    typedef logic [1:0] acc_state_t;
    localparam acc_state_t AccIdle   = 2'd0;
    localparam acc_state_t AccAccess = 2'd1;
    localparam acc_state_t AccStall  = 2'd2;

    typedef struct packed {
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
    } apb32_req_t;

    typedef struct packed {
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
    } apb32_rsp_t;

    function automatic logic [31:0] status_word(input logic [7:0] fill, input logic full,
                                                input logic empty);
        logic [31:0] w;
        w                 = '0;
        w[7:0]            = fill;
        w[StatusFullBit]  = full;
        w[StatusEmptyBit] = empty;
        return w;
    endfunction

endpackage

// File: rtl/idma_desc64_chan_fifo.sv
// First-word-fall-through submission FIFO for one descriptor channel.
// Flush takes priority over push and pop in the same cycle.
module idma_desc64_chan_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [Depth-1:0][Width-1:0] mem_q, mem_d;
    logic [PtrW-1:0]             wptr_q, wptr_d;
    logic [PtrW-1:0]             rptr_q, rptr_d;
    logic [CntW-1:0]             count_q, count_d;
    logic                        do_push;
    logic                        do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wptr_q] = data_i;
                wptr_d        = wptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/idma_desc64_mc_reg_wrapper.sv
// Multi-channel APB doorbell front end: per-channel enable, DESC_LO latch and
// submission FIFO, with wait-state back-pressure on full FIFOs bounded by a timeout.
module idma_desc64_mc_reg_wrapper
    import idma_desc64_mc_pkg::*;
#(
    parameter int unsigned NumChannels  = 4,
    parameter int unsigned FifoDepth    = 4,
    parameter int unsigned StallTimeout = 256,
    parameter type         apb_req_t    = idma_desc64_mc_pkg::apb32_req_t,
    parameter type         apb_rsp_t    = idma_desc64_mc_pkg::apb32_rsp_t
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  apb_req_t                         apb_req_i,
    output apb_rsp_t                         apb_rsp_o,
    output logic [NumChannels-1:0]           desc_valid_o,
    input  logic [NumChannels-1:0]           desc_ready_i,
    output logic [NumChannels-1:0][63:0]     desc_addr_o,
    output logic [NumChannels-1:0]           chan_busy_o
);

    localparam int unsigned ChanW = (NumChannels > 1) ? $clog2(NumChannels) : 1;
    localparam int unsigned FCntW = $clog2(FifoDepth) + 1;
    localparam int unsigned TmoW  = (StallTimeout > 1) ? $clog2(StallTimeout) : 1;

    acc_state_t                    state_q, state_d;
    logic [TmoW-1:0]               stall_cnt_q, stall_cnt_d;
    logic [ChanW-1:0]              stall_chan_q, stall_chan_d;
    logic [63:0]                   stall_data_q, stall_data_d;
    logic [NumChannels-1:0]        enable_q, enable_d;
    logic [NumChannels-1:0][31:0]  desc_lo_q, desc_lo_d;

    logic [NumChannels-1:0]            push, flush, pop, fifo_full, fifo_empty;
    logic [NumChannels-1:0][FCntW-1:0] fifo_count;
    logic [63:0]                       push_data;

    logic             in_range, acc_phase, ctrl_wr, stall_tmo;
    logic [ChanW-1:0] req_chan;
    logic [1:0]       req_off;
    logic             pready, pslverr;
    logic [31:0]      prdata;

    assign in_range  = apb_req_i.paddr < 32'(NumChannels * ChanStride);
    assign req_chan  = apb_req_i.paddr[4 +: ChanW];
    assign req_off   = apb_req_i.paddr[3:2];
    assign acc_phase = apb_req_i.psel & apb_req_i.penable;
    // CTRL writes are also serviced during a stall so another master can flush/disable
    assign ctrl_wr   = acc_phase & apb_req_i.pwrite & in_range & (req_off == RegCtrl) &
                       (state_q != AccIdle);
    assign stall_tmo = (StallTimeout != 0) && (stall_cnt_q == TmoW'(StallTimeout - 1));
    assign push_data = (state_q == AccStall) ? stall_data_q
                                             : {apb_req_i.pwdata, desc_lo_q[req_chan]};

    assign desc_valid_o = enable_q & ~fifo_empty;
    assign chan_busy_o  = desc_valid_o;
    assign pop          = desc_valid_o & desc_ready_i;

    always_comb begin
        state_d      = state_q;
        stall_cnt_d  = stall_cnt_q;
        stall_chan_d = stall_chan_q;
        stall_data_d = stall_data_q;
        enable_d     = enable_q;
        desc_lo_d    = desc_lo_q;
        push         = '0;
        flush        = '0;
        pready       = 1'b0;
        pslverr      = 1'b0;
        prdata       = '0;

        if (ctrl_wr) begin
            enable_d[req_chan] = apb_req_i.pwdata[CtrlEnBit];
            flush[req_chan]    = apb_req_i.pwdata[CtrlFlushBit];
        end

        unique case (state_q)
            AccIdle: begin
                if (apb_req_i.psel && !apb_req_i.penable) state_d = AccAccess;
            end
            AccAccess: begin
                state_d = AccIdle;
                if (acc_phase) begin
                    pready = 1'b1;
                    if (!in_range) begin
                        pslverr = 1'b1;
                    end else begin
                        unique case (req_off)
                            RegCtrl: begin
                                if (!apb_req_i.pwrite) prdata[CtrlEnBit] = enable_q[req_chan];
                            end
                            RegStatus: begin
                                if (!apb_req_i.pwrite) begin
                                    prdata = status_word(8'(fifo_count[req_chan]),
                                                         fifo_full[req_chan],
                                                         fifo_empty[req_chan]);
                                end
                            end
                            RegDescLo: begin
                                if (apb_req_i.pwrite) begin
                                    for (int b = 0; b < 4; b++) begin
                                        if (apb_req_i.pstrb[b]) begin
                                            desc_lo_d[req_chan][8*b +: 8] =
                                                apb_req_i.pwdata[8*b +: 8];
                                        end
                                    end
                                end else begin
                                    prdata = desc_lo_q[req_chan];
                                end
                            end
                            RegDescHi: begin
                                if (apb_req_i.pwrite) begin
                                    if (apb_req_i.pstrb != 4'hF || !enable_q[req_chan]) begin
                                        pslverr = 1'b1;
                                    end else if (fifo_full[req_chan]) begin
                                        pready       = 1'b0;
                                        state_d      = AccStall;
                                        stall_cnt_d  = '0;
                                        stall_chan_d = req_chan;
                                        stall_data_d = {apb_req_i.pwdata, desc_lo_q[req_chan]};
                                    end else begin
                                        push[req_chan] = 1'b1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            AccStall: begin
                stall_cnt_d = stall_cnt_q + TmoW'(1);
                if (!enable_q[stall_chan_q] || flush[stall_chan_q]) begin
                    pready  = 1'b1;
                    pslverr = 1'b1;
                end else if (!fifo_full[stall_chan_q]) begin
                    pready             = 1'b1;
                    push[stall_chan_q] = 1'b1;
                end else if (stall_tmo) begin
                    pready  = 1'b1;
                    pslverr = 1'b1;
                end
                if (pready) begin
                    state_d     = AccIdle;
                    stall_cnt_d = '0;
                end
            end
            default: state_d = AccIdle;
        endcase
    end

    always_comb begin
        apb_rsp_o         = '0;
        apb_rsp_o.pready  = pready;
        apb_rsp_o.pslverr = pslverr;
        apb_rsp_o.prdata  = prdata;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= AccIdle;
            stall_cnt_q  <= '0;
            stall_chan_q <= '0;
            stall_data_q <= '0;
            enable_q     <= '0;
            desc_lo_q    <= '0;
        end else begin
            state_q      <= state_d;
            stall_cnt_q  <= stall_cnt_d;
            stall_chan_q <= stall_chan_d;
            stall_data_q <= stall_data_d;
            enable_q     <= enable_d;
            desc_lo_q    <= desc_lo_d;
        end
    end

    for (genvar c = 0; c < NumChannels; c++) begin : g_chan
        idma_desc64_chan_fifo #(
            .Depth (FifoDepth),
            .Width (64)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush[c]),
            .push_i  (push[c]),
            .data_i  (push_data),
            .pop_i   (pop[c]),
            .data_o  (desc_addr_o[c]),
            .full_o  (fifo_full[c]),
            .empty_o (fifo_empty[c]),
            .count_o (fifo_count[c])
        );
    end

endmodule

// File: tb/tb_idma_desc64_mc_reg_wrapper.sv
// Scoreboard bench: APB driver queues expected responses, a monitor checks each completed transfer.
module tb_idma_desc64_mc_reg_wrapper;
    import idma_desc64_mc_pkg::*;

    localparam int unsigned NCh = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    apb32_req_t               req;
    apb32_rsp_t               rsp;
    logic [NCh-1:0]           dvalid, dready, busy;
    logic [NCh-1:0][63:0]     daddr;

    always #5 clk = ~clk;

    idma_desc64_mc_reg_wrapper #(
        .NumChannels  (NCh),
        .FifoDepth    (4),
        .StallTimeout (16),
        .apb_req_t    (apb32_req_t),
        .apb_rsp_t    (apb32_rsp_t)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .apb_req_i    (req),
        .apb_rsp_o    (rsp),
        .desc_valid_o (dvalid),
        .desc_ready_i (dready),
        .desc_addr_o  (daddr),
        .chan_busy_o  (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        bit          chk_data;
        logic        err;
        int          waits;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: counts wait states of the current transfer and checks it on completion
    initial begin : monitor
        int   waits;
        exp_t e;
        waits = 0;
        forever begin
            @(negedge clk);
            if (req.psel && req.penable && !rst) begin
                if (rsp.pready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: got pready=1 expected no transfer");
                    end else begin
                        e = exp_q.pop_front();
                        check({e.name, ".pslverr"}, 64'(rsp.pslverr), 64'(e.err));
                        check({e.name, ".waits"}, 64'(waits), 64'(e.waits));
                        if (e.chk_data) check({e.name, ".prdata"}, 64'(rsp.prdata), 64'(e.rdata));
                    end
                    waits = 0;
                end else begin
                    waits++;
                end
            end else begin
                waits = 0;
            end
        end
    end

    task automatic apb(input string name, input logic [31:0] addr, input logic wr,
                       input logic [31:0] data, input logic [3:0] strb, input logic err,
                       input int waits, input bit chk, input logic [31:0] rdata);
        exp_t e;
        bit   done;
        e.name = name; e.rdata = rdata; e.chk_data = chk; e.err = err; e.waits = waits;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req.psel = 1'b1; req.penable = 1'b0; req.paddr = addr;
        req.pwrite = wr; req.pwdata = data; req.pstrb = strb;
        @(posedge clk); #1;
        req.penable = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (rsp.pready) done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no pready in 200 cycles expected completion", name);
        end
        @(posedge clk); #1;
        req.psel = 1'b0; req.penable = 1'b0;
    endtask

    task automatic wr(input string name, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic err, input int waits);
        apb(name, addr, 1'b1, data, strb, err, waits, 1'b0, 32'h0);
    endtask

    task automatic rd(input string name, input logic [31:0] addr, input logic [31:0] rdata,
                      input logic err);
        apb(name, addr, 1'b0, 32'h0, 4'h0, err, 0, 1'b1, rdata);
    endtask

    initial begin
        req    = '0;
        dready = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(dvalid), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_addr", 64'(daddr[0] | daddr[1] | daddr[2] | daddr[3]), 64'h0);
        check("rst_pready", 64'(rsp.pready), 64'h0);
        check("rst_prdata", 64'(rsp.prdata), 64'h0);
        check("rst_pslverr", 64'(rsp.pslverr), 64'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Single doorbell on ch1
        wr("ch1_en", 32'h10, 32'h1, 4'hF, 1'b0, 0);
        wr("ch1_lo", 32'h18, 32'h1000, 4'hF, 1'b0, 0);
        wr("ch1_hi", 32'h1C, 32'h2, 4'hF, 1'b0, 0);
        check("ch1_valid", 64'(dvalid[1]), 64'h1);
        check("ch1_busy", 64'(busy[1]), 64'h1);
        check("ch1_addr", daddr[1], 64'h0000_0002_0000_1000);
        rd("ch1_status", 32'h14, 32'h0000_0001, 1'b0);
        rd("ch1_ctrl", 32'h10, 32'h1, 1'b0);
        wr("ch1_lo_part", 32'h18, 32'hFFFF_FFFF, 4'b0101, 1'b0, 0);
        rd("ch1_lo_rd", 32'h18, 32'h00FF_10FF, 1'b0);
        wr("ch1_dis", 32'h10, 32'h0, 4'hF, 1'b0, 0);
        check("ch1_dis_valid", 64'(dvalid[1]), 64'h0);
        rd("ch1_dis_status", 32'h14, 32'h0000_0001, 1'b0);
        wr("ch1_reen", 32'h10, 32'h1, 4'hF, 1'b0, 0);
        check("ch1_reen_addr", daddr[1], 64'h0000_0002_0000_1000);

        // Fill ch0, then a stalled doorbell released by one pop after 10 cycles
        wr("ch0_en", 32'h0, 32'h1, 4'hF, 1'b0, 0);
        wr("ch0_lo", 32'h8, 32'hA000_0000, 4'hF, 1'b0, 0);
        for (int i = 0; i < 4; i++) wr("ch0_fill", 32'hC, 32'(i), 4'hF, 1'b0, 0);
        rd("ch0_full_status", 32'h4, 32'h0000_0104, 1'b0);
        check("ch0_head", daddr[0], 64'h0000_0000_A000_0000);
        fork
            wr("ch0_stall_push", 32'hC, 32'h55, 4'hF, 1'b0, 11);
        join_none
        wait (req.penable === 1'b1);
        repeat (10) @(posedge clk);
        #1 dready[0] = 1'b1;
        @(posedge clk);
        #1 dready[0] = 1'b0;
        wait (req.psel === 1'b0);
        rd("ch0_after_status", 32'h4, 32'h0000_0104, 1'b0);
        check("ch0_head2", daddr[0], 64'h0000_0001_A000_0000);

        // Timeout on full ch2
        wr("ch2_en", 32'h20, 32'h1, 4'hF, 1'b0, 0);
        for (int i = 0; i < 4; i++) wr("ch2_fill", 32'h2C, 32'(i), 4'hF, 1'b0, 0);
        wr("ch2_timeout", 32'h2C, 32'h99, 4'hF, 1'b1, 16);
        rd("ch2_status", 32'h24, 32'h0000_0104, 1'b0);

        // Doorbell errors and out-of-range access
        wr("ch3_disabled_hi", 32'h3C, 32'h1, 4'hF, 1'b1, 0);
        wr("ch3_en", 32'h30, 32'h1, 4'hF, 1'b0, 0);
        wr("ch3_partial_hi", 32'h3C, 32'h1, 4'h3, 1'b1, 0);
        rd("ch3_status", 32'h34, 32'h0000_0200, 1'b0);
        check("ch3_valid", 64'(dvalid[3]), 64'h0);
        rd("oor_rd", 32'h100, 32'h0, 1'b1);
        wr("oor_wr", 32'h100, 32'h3, 4'hF, 1'b1, 0);

        // Stalled ch0 doorbell aborted by a flush from a second master
        fork
            wr("ch0_stall_flush", 32'hC, 32'h77, 4'hF, 1'b1, 3);
        join_none
        wait (req.penable === 1'b1);
        repeat (3) @(posedge clk);
        #1;
        req.paddr  = 32'h0;
        req.pwdata = 32'h3;
        wait (req.psel === 1'b0);
        rd("ch0_flushed_status", 32'h4, 32'h0000_0200, 1'b0);
        check("ch0_flushed_valid", 64'(dvalid[0]), 64'h0);
        rd("ch0_ctrl_after", 32'h0, 32'h1, 1'b0);

        // Reset asserted while a ch2 doorbell is stalled
        @(posedge clk); #1;
        req.psel = 1'b1; req.penable = 1'b0; req.paddr = 32'h2C;
        req.pwrite = 1'b1; req.pwdata = 32'h5; req.pstrb = 4'hF;
        @(posedge clk); #1 req.penable = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst2_pready", 64'(rsp.pready), 64'h0);
        check("rst2_pslverr", 64'(rsp.pslverr), 64'h0);
        check("rst2_prdata", 64'(rsp.prdata), 64'h0);
        check("rst2_valid", 64'(dvalid), 64'h0);
        check("rst2_busy", 64'(busy), 64'h0);
        check("rst2_addr", 64'(daddr[0] | daddr[1] | daddr[2] | daddr[3]), 64'h0);
        req = '0;
        @(posedge clk); #1 rst = 1'b0;
        rd("ch2_rst_status", 32'h24, 32'h0000_0200, 1'b0);
        rd("ch0_rst_status", 32'h4, 32'h0000_0200, 1'b0);
        rd("ch2_rst_ctrl", 32'h20, 32'h0, 1'b0);

        repeat (3) @(posedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
